alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequential issue controller that drives the combinational ALU. It accepts 32-bit instruction words over a valid/ready handshake and owns a 16 x 32 register file. For each instruction it reads the two source operands, presents optcode/operands/shift to the ALU, captures the ALU result and flags, and writes the result back. It sits between the instruction source (host or fetch stage) and the ALU.

## Interface
- NREGS, 16, register-file depth; register address width is 4.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears state, register file, outputs
- instr_valid  in  1  instruction word present
- instr_ready  out  1  high only in IDLE; reset 1
- instr  in  32  [31:28] optcode, [27:24] rd, [23:20] rs2, [19:16] rs3, [15:11] shift, [10:0] ignored
- ld_en  in  1  host register write; honored only while instr_ready=1
- ld_addr  in  4  host write address
- ld_data  in  32  host write data
- rd_addr  in  4  debug read address
- rd_data  out  32  combinational read of register rd_addr (r0 reads 0)
- alu_optcode  out  4  to ALU; registered; reset 0
- alu_r2  out  32  operand A to ALU; registered; reset 0
- alu_r3  out  32  operand B to ALU; registered; reset 0
- alu_shift  out  5  shift amount to ALU; registered; reset 0
- alu_r1  in  32  ALU result
- alu_flags  in  4  ALU flags n,z,v,c
- result  out  32  last captured ALU result; reset 0
- flags_n_z_v_c  out  4  last captured flags; reset 0
- done  out  1  one-cycle pulse in the WB cycle; reset 0
- illegal  out  1  one-cycle pulse with done for optcode 10-15; reset 0

## Operation
- FSM states: IDLE, READ, EXEC, WB. Reset enters IDLE.
- IDLE: instr_ready=1. On instr_valid=1, latch instr and go to READ. A host ld_en in the same cycle is performed, and READ sees the new value. ld_en outside IDLE is dropped silently.
- READ: read regs[rs2] and regs[rs3]. Latch them into alu_r2 and alu_r3, latch optcode into alu_optcode and shift into alu_shift. Go to EXEC.
- EXEC: ALU output settles. Capture alu_r1 into result and alu_flags into flags_n_z_v_c, except for illegal optcodes, where both hold their previous values. Go to WB.
- WB: assert done. Write result to regs[rd] at the cycle end only if optcode is 0-8 and rd != 0. Go to IDLE.
- Optcodes: 0 add, 1 sub, 2 mul, 3 or, 4 and, 5 xor, 6 shr, 7 shl, 8 ror, 9 cmp.
- Optcode 9 (cmp): the ALU maps it to sub. Flags and result are updated, but there is no register writeback.
- Optcodes 10-15: illegal pulses with done. No writeback, and result/flags are unchanged.
- r0 is hardwired to 0: writes from WB or ld_en are discarded, and reads return 0.
- The register file is a plain 32-bit store with no width conversion; the ALU defines the arithmetic (wrap-around mod 2^32, low 32 bits of mul).
- Reset in any state: return to IDLE next cycle, zero all registers, and zero all outputs except instr_ready=1. An in-flight instruction is discarded with no done.

## Timing
- Accept at edge T (instr_valid & instr_ready).
- READ occupies cycle T..T+1 and operands reach the ALU after edge T+1. EXEC occupies T+1..T+2 and result/flags are valid after edge T+2.
- WB cycle: done=1 between edges T+2 and T+3. The regfile is updated at edge T+3.
- instr_ready returns high after edge T+3, so the next accept is at the earliest edge T+4. Throughput is 1 instruction per 4 cycles.
- rd_data shows a written-back value from edge T+3 onward.
- If instr_valid is held high continuously, instructions are consumed at T, T+4, T+8, and so on. instr must be held stable until accepted.
- ALU is combinational: the alu_r1→result path must close in one cycle.

## Test plan
- Basic add: ld r1=5, ld r2=7, issue add rd=3 rs2=1 rs3=2.
  - done pulses 3 cycles after accept and rd_data(3)=12.
  - flags z=0, and illegal=0 throughout.
- cmp: ld r4=0x10, issue cmp rd=5 rs2=4 rs3=4.
  - z=1 in flags_n_z_v_c and result=0.
  - r5 is unchanged (still 0).
- Illegal and r0 handling:
  - Issue optcode 12: illegal and done pulse together, and result, flags and all registers are unchanged.
  - Issue add rd=0: r0 reads 0.
- Back-to-back: hold instr_valid high with two adds (r6=r1+r1, then r7=r6+r1, with r1=5).
  - Accepts occur 4 cycles apart and r7=15, which proves the dependency is resolved.
- ld_en while busy: assert ld_en to r8=0xFF during EXEC. The write is dropped and r8 stays 0.
- Reset mid-op: assert reset during EXEC.
  - No done pulse.
  - Next cycle instr_ready=1, result=0 and flags=0.
  - All registers read 0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Sequential issue controller for a combinational ALU: accepts one instruction
// every four cycles, reads a 16 x 32 register file, drives the ALU and writes back.
module alu_issue_ctrl #(
    parameter int NREGS = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic [31:0]                instr,
    input  logic                       ld_en,
    input  logic [$clog2(NREGS)-1:0]   ld_addr,
    input  logic [31:0]                ld_data,
    input  logic [$clog2(NREGS)-1:0]   rd_addr,
    output logic [31:0]                rd_data,
    output logic [3:0]                 alu_optcode,
    output logic [31:0]                alu_r2,
    output logic [31:0]                alu_r3,
    output logic [4:0]                 alu_shift,
    input  logic [31:0]                alu_r1,
    input  logic [3:0]                 alu_flags,
    output logic [31:0]                result,
    output logic [3:0]                 flags_n_z_v_c,
    output logic                       done,
    output logic                       illegal
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t            state, next_state;
    logic [20:0]       instr_q;
    logic [31:0]       regs [NREGS];
    logic              unused_instr_bits;

    logic [3:0]        op;
    logic [AW-1:0]     rd, rs2, rs3;
    logic [4:0]        sh;
    logic [31:0]       rs2_val, rs3_val;
    logic              op_legal, op_writes, wb_en, ld_ok;

    // Only the upper 21 bits of the instruction word carry fields.
    assign unused_instr_bits = ^instr[10:0];

    assign op  = instr_q[20:17];
    assign rd  = instr_q[16:13];
    assign rs2 = instr_q[12:9];
    assign rs3 = instr_q[8:5];
    assign sh  = instr_q[4:0];

    assign op_legal  = (op <= 4'd9);
    assign op_writes = (op <= 4'd8);
    assign wb_en     = (state == WB) && op_writes && (rd != '0);
    assign ld_ok     = ld_en && (state == IDLE) && (ld_addr != '0);

    // r0 is forced to zero on every read path, independent of storage contents.
    assign rs2_val = (rs2 == '0) ? '0 : regs[rs2];
    assign rs3_val = (rs3 == '0) ? '0 : regs[rs3];
    assign rd_data = (rd_addr == '0) ? '0 : regs[rd_addr];

    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking assignments here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        unique case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) next_state = READ;
            end
            READ: next_state = EXEC;
            EXEC: next_state = WB;
            WB: begin
                done       = 1'b1;
                illegal    = !op_legal;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q       <= '0;
            alu_optcode   <= '0;
            alu_r2        <= '0;
            alu_r3        <= '0;
            alu_shift     <= '0;
            result        <= '0;
            flags_n_z_v_c <= '0;
        end else begin
            if (state == IDLE && instr_valid) instr_q <= instr[31:11];
            if (state == READ) begin
                alu_optcode <= op;
                alu_r2      <= rs2_val;
                alu_r3      <= rs3_val;
                alu_shift   <= sh;
            end
            // Illegal optcodes leave the last legal result and flags visible.
            if (state == EXEC && op_legal) begin
                result        <= alu_r1;
                flags_n_z_v_c <= alu_flags;
            end
        end
    end

    // NOTE: the register file must read as zero after reset, so it is cleared
    // with a loop here; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (ld_ok) begin
            regs[ld_addr] <= ld_data;
        end else if (wb_en) begin
            regs[rd] <= result;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: plays the combinational ALU and
// compares the controller against an instruction-level reference model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic [3:0]  alu_optcode;
    logic [31:0] alu_r2, alu_r3;
    logic [4:0]  alu_shift;
    logic [31:0] alu_r1;
    logic [3:0]  alu_flags;
    logic [31:0] result;
    logic [3:0]  flags_n_z_v_c;
    logic        done, illegal;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_acc = -100;
    bit prev_hold = 1'b0;

    logic [31:0] m_regs [16];
    logic [31:0] m_result;
    logic [3:0]  m_flags;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_optcode(alu_optcode), .alu_r2(alu_r2), .alu_r3(alu_r3), .alu_shift(alu_shift),
        .alu_r1(alu_r1), .alu_flags(alu_flags),
        .result(result), .flags_n_z_v_c(flags_n_z_v_c),
        .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU behaviour: returns {n,z,v,c, result}.
    function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] s);
        logic [32:0] w;
        logic [31:0] r;
        logic        v, c;
        v = 1'b0; c = 1'b0; r = '0; w = '0;
        case (op)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0]; c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1, 4'd9: begin
                r = a - b; c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2: r = a * b;
            4'd3: r = a | b;
            4'd4: r = a & b;
            4'd5: r = a ^ b;
            4'd6: r = a >> s;
            4'd7: r = a << s;
            4'd8: r = (s == 5'd0) ? a : ((a >> s) | (a << (32 - int'(s))));
            default: r = '0;
        endcase
        return {r[31], (r == 32'd0), v, c, r};
    endfunction

    always_comb {alu_flags, alu_r1} = alu_fn(alu_optcode, alu_r2, alu_r3, alu_shift);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [3:0] a, input string tag);
        rd_addr = a;
        #1;
        check(tag, rd_data, m_regs[a]);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) read_reg(4'(i), $sformatf("%s_r%0d", tag, i));
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_result = '0;
        m_flags  = '0;
    endtask

    task automatic ld(input logic [3:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
        if (a != 4'd0) m_regs[a] = d;
    endtask

    // mode 0: normal, 1: host write attempted during EXEC, 2: reset during EXEC
    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs2,
                         input logic [3:0] rs3, input logic [4:0] s, input int mode,
                         input bit hold, input bit with_ld, input logic [3:0] la,
                         input logic [31:0] lv);
        int          waited;
        logic [35:0] e;
        logic [31:0] a, b;
        logic        ill;
        waited = 0;
        while (!instr_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!instr_ready) begin
            check("ready_timeout", {31'd0, instr_ready}, 32'd1);
            return;
        end
        instr = {op, rd, rs2, rs3, s, 11'($urandom)};
        instr_valid = 1'b1;
        if (with_ld) begin
            ld_en = 1'b1; ld_addr = la; ld_data = lv;
        end
        step();                                    // accept edge T
        if (with_ld) begin
            ld_en = 1'b0;
            if (la != 4'd0) m_regs[la] = lv;
        end
        if (!hold) instr_valid = 1'b0;
        if (prev_hold) check("b2b_gap", 32'(cyc - last_acc), 32'd4);
        last_acc = cyc;
        check("ready_busy", {31'd0, instr_ready}, 32'd0);
        check("done_early", {31'd0, done}, 32'd0);
        a = m_regs[rs2];
        b = m_regs[rs3];
        step();                                    // T+1: operands at ALU
        check("alu_r2", alu_r2, a);
        check("alu_r3", alu_r3, b);
        check("alu_op", {28'd0, alu_optcode}, {28'd0, op});
        check("alu_sh", {27'd0, alu_shift}, {27'd0, s});
        if (mode == 1) begin
            ld_en = 1'b1; ld_addr = la; ld_data = lv;
        end
        if (mode == 2) reset = 1'b1;
        step();                                    // T+2
        ld_en = 1'b0;
        if (mode == 2) begin
            reset = 1'b0;
            model_clear();
            prev_hold = 1'b0;
            check("rst_done", {31'd0, done}, 32'd0);
            check("rst_ready", {31'd0, instr_ready}, 32'd1);
            check("rst_result", result, 32'd0);
            check("rst_flags", {28'd0, flags_n_z_v_c}, 32'd0);
            check("rst_alu_r2", alu_r2, 32'd0);
            return;
        end
        ill = (op >= 4'd10);
        if (!ill) begin
            e = alu_fn(op, a, b, s);
            m_result = e[31:0];
            m_flags  = e[35:32];
        end
        check("done_wb", {31'd0, done}, 32'd1);
        check("illegal_wb", {31'd0, illegal}, {31'd0, ill});
        check("result", result, m_result);
        check("flags", {28'd0, flags_n_z_v_c}, {28'd0, m_flags});
        step();                                    // T+3: writeback edge
        if (op <= 4'd8 && rd != 4'd0) m_regs[rd] = m_result;
        check("done_end", {31'd0, done}, 32'd0);
        check("illegal_end", {31'd0, illegal}, 32'd0);
        check("ready_back", {31'd0, instr_ready}, 32'd1);
        read_reg(rd, "wb_rd");
        prev_hold = hold;
    endtask

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 4))
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
        model_clear();
        step(); step();
        reset = 1'b0;

        check("reset_ready", {31'd0, instr_ready}, 32'd1);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_illegal", {31'd0, illegal}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_flags", {28'd0, flags_n_z_v_c}, 32'd0);
        check("reset_alu_op", {28'd0, alu_optcode}, 32'd0);
        sweep("reset");

        // Basic add: r3 = r1 + r2
        ld(4'd1, 32'd5);
        ld(4'd2, 32'd7);
        issue(4'd0, 4'd3, 4'd1, 4'd2, 5'd0, 0, 1'b0, 1'b0, 4'd0, 32'd0);
        rd_addr = 4'd3; #1;
        check("add_r3", rd_data, 32'd12);
        check("add_z", {31'd0, flags_n_z_v_c[2]}, 32'd0);

        // cmp: flags and result update, no writeback
        ld(4'd4, 32'h10);
        issue(4'd9, 4'd5, 4'd4, 4'd4, 5'd0, 0, 1'b0, 1'b0, 4'd0, 32'd0);
        check("cmp_z", {31'd0, flags_n_z_v_c[2]}, 32'd1);
        check("cmp_result", result, 32'd0);
        rd_addr = 4'd5; #1;
        check("cmp_r5", rd_data, 32'd0);

        // Illegal optcode, then writes to r0
        issue(4'd12, 4'd6, 4'd1, 4'd2, 5'd3, 0, 1'b0, 1'b0, 4'd0, 32'd0);
        sweep("illegal");
        issue(4'd0, 4'd0, 4'd1, 4'd2, 5'd0, 0, 1'b0, 1'b0, 4'd0, 32'd0);
        ld(4'd0, 32'hDEAD_BEEF);
        rd_addr = 4'd0; #1;
        check("r0_zero", rd_data, 32'd0);

        // Back-to-back with instr_valid held: r6 = r1 + r1, r7 = r6 + r1
        issue(4'd0, 4'd6, 4'd1, 4'd1, 5'd0, 0, 1'b1, 1'b0, 4'd0, 32'd0);
        issue(4'd0, 4'd7, 4'd6, 4'd1, 5'd0, 0, 1'b0, 1'b0, 4'd0, 32'd0);
        rd_addr = 4'd7; #1;
        check("b2b_r7", rd_data, 32'd15);

        // Host write while busy is dropped
        issue(4'd0, 4'd9, 4'd1, 4'd2, 5'd0, 1, 1'b0, 1'b0, 4'd8, 32'hFF);
        rd_addr = 4'd8; #1;
        check("busy_ld_r8", rd_data, 32'd0);

        // Reset during EXEC
        issue(4'd2, 4'd10, 4'd1, 4'd2, 5'd0, 2, 1'b0, 1'b0, 4'd0, 32'd0);
        sweep("midrst");

        // Randomized traffic
        for (int i = 0; i < 4; i++) ld(4'($urandom_range(1, 15)), rand_data());
        for (int it = 0; it < 80; it++) begin
            logic [3:0] op;
            bit         hold;
            op   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                               : 4'($urandom_range(0, 9));
            hold = (it != 79) && ($urandom_range(0, 2) == 0);
            if (!prev_hold && $urandom_range(0, 3) == 0)
                ld(4'($urandom_range(0, 15)), rand_data());
            issue(op, 4'($urandom), 4'($urandom), 4'($urandom), 5'($urandom),
                  0, hold, ($urandom_range(0, 3) == 0), 4'($urandom), rand_data());
        end
        sweep("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
